// File: rtl/sub_bla_serial.sv
// Nibble-serial subtractor: d = a - b - bi, one 4-bit borrow-lookahead slice per cycle,
// LSB slice first, behind a valid/ready handshake on both sides.
module sub_bla_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, d_reg;
   logic [WIDTH-1:0] d_shift;
   logic [CW-1:0]    cnt_reg;
   logic             borrow_reg;
   logic             a_msb_reg, b_msb_reg;
   logic             bo_reg, ovf_reg, zero_reg;
   logic             last_slice;

   logic [3:0] g, p, slice_d;
   logic [4:0] c;

   // Per-bit borrow generate/propagate and difference for the current low nibble
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bit
         assign g[gi]       = ~a_reg[gi] & b_reg[gi];
         assign p[gi]       = ~(a_reg[gi] ^ b_reg[gi]);
         assign slice_d[gi] = a_reg[gi] ^ b_reg[gi] ^ c[gi];
      end
   endgenerate

   // Fully expanded lookahead; every borrow depends directly on c[0]
   assign c[0] = borrow_reg;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

   generate
      if (N > 1) begin : g_shift_multi
         assign d_shift = {slice_d, d_reg[WIDTH-1:4]};
      end else begin : g_shift_single
         assign d_shift = slice_d;
      end
   endgenerate

   assign last_slice = (cnt_reg == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_slice) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         d_reg      <= '0;
         cnt_reg    <= '0;
         borrow_reg <= 1'b0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         bo_reg     <= 1'b0;
         ovf_reg    <= 1'b0;
         zero_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg      <= a;
                  b_reg      <= b;
                  borrow_reg <= bi;
                  cnt_reg    <= '0;
                  a_msb_reg  <= a[WIDTH-1];
                  b_msb_reg  <= b[WIDTH-1];
               end
            end
            RUN: begin
               a_reg      <= a_reg >> 4;
               b_reg      <= b_reg >> 4;
               d_reg      <= d_shift;
               borrow_reg <= c[4];
               cnt_reg    <= cnt_reg + CW'(1);
               // Flags are frozen on the last slice so they hold steady through DONE
               if (last_slice) begin
                  bo_reg   <= c[4];
                  ovf_reg  <= (a_msb_reg != b_msb_reg) & (slice_d[3] != a_msb_reg);
                  zero_reg <= (d_shift == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign d    = d_reg;
   assign bo   = bo_reg;
   assign ovf  = ovf_reg;
   assign zero = zero_reg;

endmodule

// File: tb/tb_sub_bla_serial.sv
// Self-checking bench for sub_bla_serial: vector table plus handshake/reset corner sequences,
// with expected results queued at stimulus time and popped when out_valid appears.
module tb_sub_bla_serial;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bi;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] d;
   logic         bo;
   logic         ovf;
   logic         zero;

   sub_bla_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bi        (bi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bo        (bo),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      logic [W-1:0] d;
      logic         bo;
      logic         ovf;
      logic         zero;
   } vec_t;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ovf;
      logic         zero;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[14];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Arithmetic reference: widen to W+1 bits, the extra bit is the borrow
   function automatic vec_t ref_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbi);
      vec_t      v;
      logic [W:0] full;
      full   = {1'b0, va} - {1'b0, vb} - {{W{1'b0}}, vbi};
      v.a    = va;
      v.b    = vb;
      v.bi   = vbi;
      v.d    = full[W-1:0];
      v.bo   = full[W];
      v.ovf  = (va[W-1] != vb[W-1]) && (full[W-1] != va[W-1]);
      v.zero = (full[W-1:0] == '0);
      return v;
   endfunction

   function automatic exp_t to_exp(input vec_t v);
      exp_t e;
      e.d    = v.d;
      e.bo   = v.bo;
      e.ovf  = v.ovf;
      e.zero = v.zero;
      return e;
   endfunction

   task automatic compare_result(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s unexpected_result actual=%0h required=none", tag, d);
      end else begin
         e = sb_q.pop_front();
         check({tag, " d"},    d,    e.d);
         check({tag, " bo"},   bo,   e.bo);
         check({tag, " ovf"},  ovf,  e.ovf);
         check({tag, " zero"}, zero, e.zero);
      end
   endtask

   // Issue one operation, wait (bounded) for out_valid, compare, then consume with out_ready
   task automatic do_op(input vec_t v, input string tag);
      int lat;
      check({tag, " in_ready_idle"}, in_ready, 1'b1);
      a        = v.a;
      b        = v.b;
      bi       = v.bi;
      in_valid = 1'b1;
      sb_q.push_back(to_exp(v));
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, 4);
      if (out_valid) begin
         compare_result(tag);
      end else begin
         void'(sb_q.pop_front());
      end
      $display("txn %s: a=%h b=%h bi=%0d -> d=%h bo=%0d ovf=%0d zero=%0d lat=%0d",
               tag, v.a, v.b, v.bi, d, bo, ovf, zero, lat);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " in_ready_after"}, in_ready, 1'b1);
      check({tag, " out_valid_after"}, out_valid, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      int   cnt;
      int   cnt_ir;
      exp_t e;

      vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      for (int i = 8; i < 14; i++) begin
         vecs[i] = ref_vec(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      bi        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready",  in_ready,  1'b1);
      check("reset out_valid", out_valid, 1'b0);
      check("reset d",         d,         16'h0000);
      check("reset bo",        bo,        1'b0);
      check("reset ovf",       ovf,       1'b0);
      check("reset zero",      zero,      1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         do_op(vecs[i], $sformatf("vec%0d", i));
      end

      // Backpressure: result held for 3 cycles while a second operand is offered
      v = vecs[0];
      a = v.a; b = v.b; bi = v.bi; in_valid = 1'b1;
      sb_q.push_back(to_exp(v));
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("bp latency", cnt, 4);
      e = sb_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         a = 16'hFFFF; b = 16'h0001; bi = 1'b0; in_valid = 1'b1;
         check("bp out_valid", out_valid, 1'b1);
         check("bp in_ready",  in_ready,  1'b0);
         check("bp d_held",    d,         e.d);
         check("bp bo_held",   bo,        e.bo);
         check("bp ovf_held",  ovf,       e.ovf);
         check("bp zero_held", zero,      e.zero);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp out_valid_end", out_valid, 1'b1);
      check("bp d_end", d, e.d);
      $display("txn bp: held d=%h for 3 cycles, second operand offered", d);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp in_ready_after", in_ready, 1'b1);
      check("bp out_valid_after", out_valid, 1'b0);
      cnt = 0; cnt_ir = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) cnt++;
         if (!in_ready) cnt_ir++;
         @(posedge clk); #1;
      end
      check("bp second_ignored_valid", cnt, 0);
      check("bp second_ignored_busy", cnt_ir, 0);

      // out_ready held high throughout: exactly one out_valid cycle
      out_ready = 1'b1;
      v = vecs[4];
      a = v.a; b = v.b; bi = v.bi; in_valid = 1'b1;
      sb_q.push_back(to_exp(v));
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) begin
            cnt++;
            compare_result("ordy");
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check("ordy valid_cycles", cnt, 1);
      $display("txn ordy: a=%h b=%h out_valid_cycles=%0d", v.a, v.b, cnt);
      sb_q.delete();

      // Reset asserted during the second RUN cycle aborts the operation
      a = 16'h4321; b = 16'h1111; bi = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid in_ready",  in_ready,  1'b1);
      check("rst_mid out_valid", out_valid, 1'b0);
      check("rst_mid d",         d,         16'h0000);
      check("rst_mid bo",        bo,        1'b0);
      check("rst_mid zero",      zero,      1'b0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) cnt++;
         @(posedge clk); #1;
      end
      check("rst_mid no_result", cnt, 0);
      $display("txn rst_mid: aborted 4321-1111, out_valid_cycles=%0d", cnt);
      do_op('{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0}, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
